// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline inter-stage registers: default control
// width, decode-flag bit positions and field offsets of the default payload.
package pipe_pkg;

  // Default width of the one-hot decode-control vector.
  localparam int CTRL_W_DEF = 10;

  // Decode-flag bit indices inside the control vector.
  localparam int CTL_COMPUTE     = 0;
  localparam int CTL_COMPUTE_IMM = 1;
  localparam int CTL_LW          = 2;
  localparam int CTL_SW          = 3;
  localparam int CTL_LHB         = 4;
  localparam int CTL_LLB         = 5;
  localparam int CTL_B           = 6;
  localparam int CTL_BR          = 7;
  localparam int CTL_PCS         = 8;
  localparam int CTL_HLT         = 9;

  // Field layout of the default 96-bit payload, 16-bit fields from bit 0.
  localparam int FIELD_W   = 16;
  localparam int OFF_INSTR = 0;
  localparam int OFF_PC    = 16;
  localparam int OFF_RF1   = 32;
  localparam int OFF_RF2   = 48;
  localparam int OFF_ALU   = 64;
  localparam int OFF_DM    = 80;
  localparam int DATA_W_DEF = 96;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid flag, payload and decode-control register.
// Clear turns the slot into a bubble (valid and ctrl zero) but keeps data;
// reset additionally loads the payload reset value. Clear beats load.
module pipe_slot #(
  parameter int                DATA_W       = 96,
  parameter int                CTRL_W       = 10,
  parameter logic [DATA_W-1:0] DATA_RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // Slot register: reset, then clear-to-bubble, then load.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= DATA_RST_VAL;
    end else if (clr) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= d_ctrl;
      data  <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a one-entry skid buffer.
//
// Handshake: a word moves upstream->stage when in_valid & in_ready at a
// rising edge, and stage->downstream when out_valid & out_ready at a rising
// edge. in_ready and out_valid are registers; in_ready is the registered
// "skid slot empty" flag, so it never depends combinationally on out_ready.
// Once out_valid is high, out_valid/out_data/out_ctrl hold until popped,
// unless rst or flush intervenes. Slot S is always younger than slot M.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W       = DATA_W_DEF,
  parameter int                CTRL_W       = CTRL_W_DEF,
  parameter logic [DATA_W-1:0] DATA_RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              m_valid, s_valid;
  logic [DATA_W-1:0] m_data, s_data;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic              acc, pop;
  logic              m_load, m_clr, m_from_s;
  logic              s_load, s_clr;
  logic              s_valid_nxt;
  logic [DATA_W-1:0] m_d_data;
  logic [CTRL_W-1:0] m_d_ctrl;

  assign acc = in_valid & in_ready;
  assign pop = m_valid & out_ready;

  // Slot control: flush empties both slots; otherwise M refills from S
  // first (FIFO order), then from the input, and S catches the word that
  // arrives while M is stalled.
  always_comb begin
    m_load   = 1'b0;
    m_clr    = 1'b0;
    m_from_s = 1'b0;
    s_load   = 1'b0;
    s_clr    = 1'b0;
    if (flush) begin
      m_clr = 1'b1;
      s_clr = 1'b1;
    end else if (!m_valid) begin
      m_load = acc;
    end else if (pop) begin
      if (s_valid) begin
        m_load   = 1'b1;
        m_from_s = 1'b1;
        s_clr    = 1'b1;
      end else if (acc) begin
        m_load = 1'b1;
      end else begin
        m_clr = 1'b1;
      end
    end else if (acc) begin
      s_load = 1'b1;
    end
  end

  assign m_d_data = m_from_s ? s_data : in_data;
  assign m_d_ctrl = m_from_s ? s_ctrl : in_ctrl;

  // Next value of the skid valid flag, used to pre-compute in_ready.
  always_comb begin
    s_valid_nxt = s_valid;
    if (s_clr)       s_valid_nxt = 1'b0;
    else if (s_load) s_valid_nxt = 1'b1;
  end

  // in_ready register: high whenever the skid slot will be empty.
  always_ff @(posedge clk) begin
    if (rst) in_ready <= 1'b1;
    else     in_ready <= ~s_valid_nxt;
  end

  pipe_slot #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .DATA_RST_VAL(DATA_RST_VAL)
  ) u_main (
    .clk(clk), .rst(rst), .clr(m_clr), .load(m_load),
    .d_data(m_d_data), .d_ctrl(m_d_ctrl),
    .valid(m_valid), .data(m_data), .ctrl(m_ctrl)
  );

  pipe_slot #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .DATA_RST_VAL(DATA_RST_VAL)
  ) u_skid (
    .clk(clk), .rst(rst), .clr(s_clr), .load(s_load),
    .d_data(in_data), .d_ctrl(in_ctrl),
    .valid(s_valid), .data(s_data), .ctrl(s_ctrl)
  );

  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_ctrl  = m_ctrl;
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: directed scenarios plus a random
// ready/valid soak, checked by a negedge scoreboard monitor.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int DATA_W = 96;
  localparam int CTRL_W = 10;
  localparam int W      = DATA_W + CTRL_W;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [1:0]        occupancy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DATA_RST_VAL('0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_ctrl  = '0;
  endtask

  task automatic present(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_ctrl"},  out_ctrl,  '0);
    check({tag, "_in_ready"},  in_ready,  1'b1);
    check({tag, "_occ"},       occupancy, 2'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  // Evaluated mid-cycle: records what the coming rising edge will transfer.
  logic              prev_hold = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic [CTRL_W-1:0] prev_ctrl;

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("stable_valid", out_valid, 1'b1);
        check("stable_word", {out_data, out_ctrl}, {prev_data, prev_ctrl});
      end
      if (!out_valid) check("bubble_ctrl", out_ctrl, '0);
      check("s_implies_m", dut.s_valid & ~dut.m_valid, 1'b0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("pop_word", {out_data, out_ctrl}, e);
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back({in_data, in_ctrl});
      prev_hold = out_valid && !out_ready && !flush;
      prev_data = out_data;
      prev_ctrl = out_ctrl;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [CTRL_W-1:0] one_hot;
    logic              will_acc;
    rst = 1'b1;
    out_ready = 1'b0;
    idle_inputs();
    step(); step();
    rst = 1'b0;
    check_empty("reset");
    check("reset_out_data", out_data, '0);

    // Streaming: 8 words back to back, out_ready held high.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      present(DATA_W'(i), 10'h001);
      step();
      check("stream_in_ready", in_ready, 1'b1);
      check("stream_out_valid", out_valid, 1'b1);
      check("stream_out_data", out_data, DATA_W'(i));
    end
    idle_inputs();
    step();
    check_empty("stream_drain");

    // Skid: A stalls in M, B lands in S.
    out_ready = 1'b0;
    one_hot = '0; one_hot[CTL_COMPUTE_IMM] = 1'b1;
    present(96'hA, one_hot);
    step();
    check("skid_occ1", occupancy, 2'd1);
    check("skid_rdy1", in_ready, 1'b1);
    present(96'hB, 10'h008);
    step();
    idle_inputs();
    check("skid_occ2", occupancy, 2'd2);
    check("skid_rdy0", in_ready, 1'b0);
    check("skid_head", out_data, 96'hA);
    out_ready = 1'b1;
    step();
    check("skid_b_head", out_data, 96'hB);
    check("skid_b_ctrl", out_ctrl, 10'h008);
    check("skid_rdy_back", in_ready, 1'b1);
    check("skid_occ_b", occupancy, 2'd1);
    step();
    check_empty("skid_drain");

    // Reset mid-stream with two words held; presented word is dropped.
    out_ready = 1'b0;
    present(96'h11, 10'h001); step();
    present(96'h22, 10'h002); step();
    check("rstmid_occ2", occupancy, 2'd2);
    rst = 1'b1;
    present(96'h33, 10'h004);
    step();
    rst = 1'b0;
    idle_inputs();
    check_empty("rstmid");
    check("rstmid_out_data", out_data, '0);
    step();
    check("rstmid_hold_occ", occupancy, 2'd0);

    // Flush with a full stage; C presented alongside never appears.
    one_hot = '0; one_hot[CTL_LW] = 1'b1;
    present(96'h44, one_hot); step();
    present(96'h55, 10'h010); step();
    check("flush_occ2", occupancy, 2'd2);
    check("flush_head_ctrl", out_ctrl, 10'h004);
    present(96'h66, 10'h020);
    flush = 1'b1;
    step();
    idle_inputs();
    check_empty("flush_full");

    // Flush while a word is accepted in the same cycle.
    present(96'h77, 10'h040); step();
    present(96'h88, 10'h080);
    flush = 1'b1;
    step();
    idle_inputs();
    check_empty("flush_acc");

    // Backpressure: hold the head for five cycles, then release.
    one_hot = '0; one_hot[CTL_HLT] = 1'b1;
    present(96'h99, one_hot); step();
    present(96'hAA, 10'h100); step();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      check("bp_data", out_data, 96'h99);
      check("bp_ctrl", out_ctrl, 10'h200);
      check("bp_valid", out_valid, 1'b1);
      step();
    end
    out_ready = 1'b1;
    step();
    check("bp_second", out_data, 96'hAA);
    step();
    check_empty("bp_drain");

    // Random soak: protocol-legal valid, random ready and rare flushes.
    will_acc = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (will_acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = {$urandom, $urandom, $urandom};
        in_ctrl  = '0;
        in_ctrl[$urandom_range(0, CTRL_W - 1)] = 1'b1;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      will_acc  = in_valid && in_ready;
      step();
    end
    idle_inputs();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("soak_drained", exp_q.size(), 0);
    check_empty("soak_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised inter-stage pipeline register with a valid/ready handshake and a one-entry skid buffer.
- Carries a data payload plus a one-hot decode-control vector between stages. The control vector defaults to 10 flags: compute, compute_imm, lw, sw, lhb, llb, b, br, pcs, hlt.
- Adds three things a plain write-enabled register stage lacks: per-stage stall via backpressure, flush-to-bubble, and full throughput with a registered in_ready. There is no combinational path from out_ready to in_ready.
- Sits between any two stages of the pipelined processor (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 96, payload width in bits. The default covers six 16-bit fields: instr, pc, rf1, rf2, alu, dm.
- CTRL_W, 10, decode-control vector width. Bits are forced to 0 whenever the slot is a bubble.
- DATA_RST_VAL, 0, reset value of the payload registers (DATA_W bits).

Ports:
- clk, input, 1, sole clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- flush, input, 1, discards all held entries and turns the stage into a bubble.
- in_valid, input, 1, upstream presents a word.
- in_ready, output, 1, registered; stage can accept a word this cycle.
- in_data, input, DATA_W, upstream payload.
- in_ctrl, input, CTRL_W, upstream decode flags.
- out_valid, output, 1, registered; the main slot holds a valid word.
- out_ready, input, 1, downstream accepts this cycle.
- out_data, output, DATA_W, payload of the main slot.
- out_ctrl, output, CTRL_W, flags of the main slot; equals 0 when out_valid is 0.
- occupancy, output, 2, number of held words (0, 1 or 2).

Behaviour:
- State: main slot M (valid, data, ctrl) drives the outputs. Skid slot S (valid, data, ctrl) is internal.
- Transfers:
  - acc = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Reset (rst=1 at an edge):
  - M.valid = S.valid = 0; all ctrl = 0; all data = DATA_RST_VAL.
  - Outputs after that edge: out_valid=0, out_ctrl=0, out_data=DATA_RST_VAL, in_ready=1, occupancy=0.
  - rst takes priority over flush and over all handshakes. Words presented during a reset cycle are dropped.
  - Reset mid-operation drops both slots without emitting them.
- Flush (rst=0, flush=1):
  - M.valid, S.valid, M.ctrl and S.ctrl are cleared next cycle. Data registers hold.
  - A word accepted in the same cycle is discarded.
  - A pop in the flush cycle counts as completed (downstream consumed it).
  - in_ready=1 the following cycle.
- Normal operation (rst=0, flush=0), evaluated on the current M.valid and S.valid:
  - M empty: if acc, M <= input.
  - M full, pop, S full: M <= S; S empty. in_ready is 0 this cycle, so no accept is possible.
  - M full, pop, S empty: if acc, M <= input; else M becomes empty.
  - M full, no pop, acc: S <= input, so S becomes full.
  - M full, no pop, no acc: hold.
- in_ready is a register equal to the next value of !S.valid. It must never depend combinationally on out_ready.
- Ordering is strictly FIFO: S is always younger than M.
- Latency from an accept into an empty stage to out_valid is 1 cycle. Sustained throughput is 1 word/cycle when out_ready is held high.
- While a slot is invalid, its ctrl is 0 (bubble = NOP). Data is don't-care but holds its last value.
- occupancy = M.valid + S.valid, updated each cycle.
- Invariant: S.valid implies M.valid. The verifier asserts it every cycle.
- Upstream protocol (verifier assumes, not checked): once raised, in_valid and in_data stay stable until accepted.
- Downstream protocol (block guarantees): once out_valid rises, out_valid, out_data and out_ctrl stay stable until popped, unless rst or flush intervenes.

Decomposition:
- Package pipe_pkg:
  - CTRL_W default constant.
  - Decode-flag bit indices: CTL_COMPUTE=0, CTL_COMPUTE_IMM=1, CTL_LW=2, CTL_SW=3, CTL_LHB=4, CTL_LLB=5, CTL_B=6, CTL_BR=7, CTL_PCS=8, CTL_HLT=9.
  - Field offsets for the default 96-bit payload: instr, pc, rf1, rf2, alu, dm at 16-bit strides from bit 0.
- Sub-module pipe_slot:
  - One valid + DATA_W + CTRL_W register with a load enable and a clear.
  - Clear zeroes valid and ctrl; reset applies DATA_RST_VAL to data.
  - Instantiated twice (M and S). Top level holds the control logic and the in_ready register.

Test Plan:
- Reset mid-stream: two words held (occupancy=2), assert rst one cycle → next cycle out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0.
- Streaming: in_valid=1 for 8 cycles with data 0x1..0x8 and ctrl=0x001, out_ready=1 → out_valid rises 1 cycle after the first accept; 0x1..0x8 emitted on consecutive cycles; in_ready stays 1.
- Skid: word A accepted; out_ready=0; word B presented → B goes to S, occupancy=2, in_ready=0 next cycle. Release out_ready → A popped, then B popped next cycle; in_ready returns to 1 one cycle after A pops.
- Flush with full stage: occupancy=2 (ctrl of A = 0x004, lw), flush=1 together with in_valid=1 (word C) → next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; C never appears at the output.
- Backpressure stability: hold out_ready=0 for 5 cycles with out_valid=1 → out_data and out_ctrl unchanged every cycle; no word lost or duplicated after release.
- Randomised ready/valid, 2000 cycles, CTRL_W=10, DATA_W=96 → output sequence equals input sequence, with flush windows excluded from the comparison; the S.valid implies M.valid assertion never fires.
